gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt: RTL and testbench
=======================================================

Name: gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt

Overview:
- Receiving-end cell for a buffered, asynchronous single-bit net.
- Synchronises input I into the CLK domain, rejects pulses shorter than FILT_CYC clocks, and drives a clean level Z.
- Also drives single-cycle RISE and FALL edge strobes.
- Placed at the sink of long buffered nets, e.g. pad inputs and cross-block control, before any sequential consumer.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count; legal 2..4.
- FILT_CYC, 4: consecutive stable sampled cycles required before Z follows; legal 1..255.
- RST_VAL, 1'b0: reset level of the synchroniser chain and of Z.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  filter enable; 0 freezes Z and clears the counter.
- I  input  1  asynchronous data in.
- Z  output  1  filtered, synchronised level.
- RISE  output  1  one-cycle strobe on the Z 0->1 transition.
- FALL  output  1  one-cycle strobe on the Z 1->0 transition.
- VDD, VSS  inout  1  present only under USE_POWER_PINS.

Behaviour:
- Reset: one clock (CLK); reset (RST) is asynchronous and active-high.
  - RST=1 immediately forces sync[*]=RST_VAL, Z=RST_VAL, cnt=0, RISE=0, FALL=0, with no clock needed.
  - Release of RST is taken at the next CLK edge. No pulse is emitted on release.
- Synchroniser:
  - sync[0]<=I; sync[k]<=sync[k-1]; s=sync[SYNC_STAGES-1].
  - No logic is permitted between the stages.
- Counter: width ceil(log2(FILT_CYC)), minimum 1. Each CLK edge, in priority order:
  - EN=0: cnt<=0; Z holds.
  - s==Z: cnt<=0.
  - s!=Z and cnt==FILT_CYC-1: Z<=s; cnt<=0.
  - otherwise: cnt<=cnt+1.
- Counter never exceeds FILT_CYC-1 and never wraps.
- Strobes: both are registered.
  - RISE<=1 on exactly the edge where Z updates 0->1; FALL likewise for 1->0.
  - Both are 0 on all other edges. RISE and FALL are never high together.
- Latency: I changes and stays stable; the first edge sampling the new value is edge 1.
  - Z and the matching strobe update at edge SYNC_STAGES+FILT_CYC.
  - Defaults: edge 6.
- Glitch rejection: if s returns to Z before cnt reaches FILT_CYC-1, cnt clears and Z does not change.
  - The next excursion restarts counting from 0. There is no accumulation across excursions.
- FILT_CYC=1: Z follows s one edge after s changes. This is the pure-synchroniser mode.
- EN deassert mid-count: the count is lost and Z keeps its old value.
  - On EN reassert, counting restarts from 0 if s!=Z.
- RST mid-count or mid-strobe: strobe drops immediately, Z returns to RST_VAL, and a partial count is discarded.
- Toggle rate: at most one Z transition per FILT_CYC cycles.
- Metastability on sync[0] is the only tolerated X source. Z, RISE and FALL must never go X after reset.
- Under FUNCTIONAL undefined, a specify block provides:
  - CLK=>Z, CLK=>RISE and CLK=>FALL arcs;
  - I setup/hold checks against posedge CLK;
  - RST recovery/removal checks.

Test Plan:
- Reset, defaults, RST_VAL=0: assert RST with CLK stopped -> Z=0, RISE=0, FALL=0 at once; release RST with I=0 for 10 cycles -> no strobes.
- Clean rise, defaults: I 0->1 just before edge 1, held -> Z=1 and RISE=1 at edge 6; RISE=0 at edge 7; FALL stays 0.
- Glitch rejection, defaults: I high for 3 cycles, then low -> Z stays 0, no RISE.
- Re-excursion, defaults: I high 3 cycles, low 1 cycle, high 4+ cycles -> Z rises 6 edges after the second rise, i.e. the count restarts.
- EN gating: I held high with EN=0 for 20 cycles -> Z=0; raise EN -> Z=1 and RISE at the 4th edge after EN=1.
- Pure-sync config, FILT_CYC=1 and SYNC_STAGES=3: toggle I every 5 cycles -> Z tracks I with 4-edge latency, alternating RISE/FALL. Then assert RST while Z=1 -> Z=0 immediately, no FALL strobe.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt
//
// Receiving-end cell for a long, buffered, asynchronous single-bit net.
// The input is brought into the CLK domain through a plain flop chain. A
// stability filter then lets Z follow the synchronised value only after it
// has disagreed with Z for FILT_CYC consecutive clocks. Registered
// single-cycle strobes mark each Z transition.
//
// Parameters
//   SYNC_STAGES : synchroniser flop count, legal 2..4
//   FILT_CYC    : consecutive disagreeing cycles before Z follows, legal 1..255
//   RST_VAL     : reset level of the synchroniser chain and of Z
//
// Ports
//   VDD, VSS : power pins, present only when USE_POWER_PINS is defined
//   CLK      : rising-edge clock
//   RST      : asynchronous, active-high reset
//   EN       : filter enable; 0 freezes Z and clears the counter
//   I        : asynchronous data in
//   Z        : filtered, synchronised level
//   RISE     : one-cycle strobe on the edge where Z goes 0->1
//   FALL     : one-cycle strobe on the edge where Z goes 1->0
//
// Latency: if I changes and then stays stable, edge 1 being the first edge
// that samples the new value, Z and its strobe update at edge
// SYNC_STAGES + FILT_CYC.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4,
    parameter logic        RST_VAL     = 1'b0
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic I,
    output logic Z,
    output logic RISE,
    output logic FALL
);

    // One counter bit is kept even for FILT_CYC=1, where the counter only
    // ever holds 0 and the filter behaves as a bare synchroniser.
    localparam int unsigned      CNT_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    // Synchroniser: a plain shift chain with nothing between the stages, so
    // that each stage gets a full cycle to resolve metastability.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], I};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Stability filter and edge strobes.
    // cnt counts consecutive cycles where s disagrees with Z. Any agreement,
    // or EN low, clears it, so separate excursions never add up. Z flips on
    // the edge where the count has already reached FILT_CYC-1 and s still
    // disagrees. That edge is the FILT_CYC-th disagreeing sample, so cnt
    // never passes CNT_LAST and never wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Z    <= RST_VAL;
            cnt  <= '0;
            RISE <= 1'b0;
            FALL <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            if (!EN) begin
                cnt <= '0;
            end else if (s == Z) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // s differs from Z here, so exactly one strobe fires.
                Z    <= s;
                cnt  <= '0;
                RISE <= s;
                FALL <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifndef FUNCTIONAL
    specify
        (CLK => Z)    = (0.0, 0.0);
        (CLK => RISE) = (0.0, 0.0);
        (CLK => FALL) = (0.0, 0.0);
        $setup(I, posedge CLK, 0.0);
        $hold(posedge CLK, I, 0.0);
        $recovery(negedge RST, posedge CLK, 0.0);
        $removal(negedge RST, posedge CLK, 0.0);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt.sv
// ---------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt.
// Two instances share one clock:
//   d_* : default configuration (SYNC_STAGES=2, FILT_CYC=4, RST_VAL=0)
//   p_* : pure-synchroniser configuration (SYNC_STAGES=3, FILT_CYC=1)
// Inputs change 1 time unit after a rising edge, so each new value is
// sampled first by the next edge. Outputs are read 1 time unit after the
// edge being checked. "Edge e" counts from the first edge that samples the
// new input value.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic clk_run = 1'b0;

    always #5 if (clk_run) clk = ~clk;

    // ---------------- DUT signals ----------------
    logic d_rst = 1'b0;
    logic d_en  = 1'b1;
    logic d_i   = 1'b0;
    logic d_z, d_rise, d_fall;

    logic p_rst = 1'b0;
    logic p_en  = 1'b1;
    logic p_i   = 1'b0;
    logic p_z, p_rise, p_fall;

    gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt u_dut (
        .CLK  (clk),
        .RST  (d_rst),
        .EN   (d_en),
        .I    (d_i),
        .Z    (d_z),
        .RISE (d_rise),
        .FALL (d_fall)
    );

    gf180mcu_fd_sc_mcu7t5v0__rxsync_dglt #(
        .SYNC_STAGES (3),
        .FILT_CYC    (1),
        .RST_VAL     (1'b0)
    ) u_psync (
        .CLK  (clk),
        .RST  (p_rst),
        .EN   (p_en),
        .I    (p_i),
        .Z    (p_z),
        .RISE (p_rise),
        .FALL (p_fall)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Wait for the next rising edge, then step past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input level driven before edge e in the pure-sync toggle pattern:
    // high for edges 1..5, low 6..10, high 11..15, low 16...
    function automatic logic p_pattern(input int e);
        return (((e - 1) / 5) % 2) == 0;
    endfunction

    // Hand-derived Z for the pure-sync instance: with 3 stages and
    // FILT_CYC=1, Z at edge e equals the level sampled at edge e-3.
    function automatic logic p_exp_z(input int e);
        return (e < 4) ? 1'b0 : p_pattern(e - 3);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Reset applied with the clock stopped must act at once.
        #3;
        d_rst = 1'b1;
        p_rst = 1'b1;
        #1;
        check("rst_async_z",    d_z,    1'b0);
        check("rst_async_rise", d_rise, 1'b0);
        check("rst_async_fall", d_fall, 1'b0);
        check("rst_async_pz",   p_z,    1'b0);

        clk_run = 1'b1;
        tick();
        tick();
        d_rst = 1'b0;  // p_rst stays high until its own test
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("rel_z",    d_z,    1'b0);
            check("rel_rise", d_rise, 1'b0);
            check("rel_fall", d_fall, 1'b0);
        end

        // Clean rise: Z and RISE at edge 6, RISE low again at edge 7.
        d_i = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("rise_z",    d_z,    (e >= 6));
            check("rise_rise", d_rise, (e == 6));
            check("rise_fall", d_fall, 1'b0);
        end

        // Clean fall, same latency.
        d_i = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check("fall_z",    d_z,    (e < 6));
            check("fall_fall", d_fall, (e == 6));
            check("fall_rise", d_rise, 1'b0);
        end

        // Glitch of 3 cycles is rejected.
        d_i = 1'b1;
        tick();
        tick();
        tick();
        d_i = 1'b0;
        for (int e = 4; e <= 12; e++) begin
            tick();
            check("glitch_z",    d_z,    1'b0);
            check("glitch_rise", d_rise, 1'b0);
        end

        // Re-excursion: high 3, low 1, then high from edge 5. The count
        // restarts, so Z rises at edge 10.
        d_i = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            check("reex_z",    d_z,    (e >= 10));
            check("reex_rise", d_rise, (e == 10));
            if (e == 3) d_i = 1'b0;
            if (e == 4) d_i = 1'b1;
        end

        // Return low with EN=1 (fall at edge 6) to prepare the EN test.
        d_i = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check("pre_en_z", d_z, 1'b0);

        // EN gating: I high with EN=0 for 20 cycles leaves Z low.
        d_en = 1'b0;
        d_i  = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("en_off_z",    d_z,    1'b0);
            check("en_off_rise", d_rise, 1'b0);
        end
        // s is already 1, so Z rises at the 4th edge after EN goes high.
        d_en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("en_on_z",    d_z,    (e >= 4));
            check("en_on_rise", d_rise, (e == 4));
        end

        // EN dropped mid-count: Z holds and the count is lost. Z=1 and I
        // goes low; two counting edges happen before EN drops.
        d_i = 1'b0;
        for (int e = 1; e <= 4; e++) tick();  // s low from edge 2, cnt=2
        d_en = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("en_mid_z", d_z, 1'b1);
        end
        d_en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("en_re_z",    d_z,    (e < 4));
            check("en_re_fall", d_fall, (e == 4));
        end

        // Pure-sync configuration: toggle I every 5 cycles.
        p_rst = 1'b0;
        tick();
        tick();
        for (int e = 1; e <= 16; e++) begin
            p_i = p_pattern(e);
            tick();
            check("psync_z",    p_z,    p_exp_z(e));
            check("psync_rise", p_rise, p_exp_z(e) & ~p_exp_z(e - 1));
            check("psync_fall", p_fall, ~p_exp_z(e) & p_exp_z(e - 1));
        end
        // Z is 1 here; reset forces it low at once with no FALL strobe.
        p_rst = 1'b1;
        #1;
        check("psync_rst_z",    p_z,    1'b0);
        check("psync_rst_fall", p_fall, 1'b0);
        tick();
        check("psync_rst_z2",    p_z,    1'b0);
        check("psync_rst_fall2", p_fall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
